// File: rtl/ejercicio_3_rr_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ejercicio_3_pkg
// Purpose  : Shared types, constants and round-robin helper for the 8-way
//            request arbiter/sequencer in front of the 16-bit 8:1 mux.
// Contents : state_t   - controller state (IDLE, SEND)
//            N_REQ     - number of requesters
//            SEL_W     - width of a requester index / mux select
//            PTR_RESET - round-robin pointer value after reset
//            rr_pick   - returns {found, idx} of first set bit after ptr
// Revision : 1.0 - initial release
// ============================================================================
package ejercicio_3_pkg;

  localparam int                N_REQ     = 8;
  localparam int                SEL_W     = 3;
  localparam logic [SEL_W-1:0]  PTR_RESET = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Search starts one past the last grant and wraps modulo N_REQ, so the
  // last-granted index is examined last. The 3-bit sum wraps naturally.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] vec,
                                             input logic [SEL_W-1:0] ptr);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ejercicio_2_b.sv
`default_nettype none
// ============================================================================
// Module   : ejercicio_2_b
// Purpose  : WIDTH-bit 8:1 multiplexer. Select {sel_3,sel_2,sel_1} = k
//            routes in_(k+1) to out.
// Ports    : in_1..in_8   in  WIDTH  data inputs
//            sel_1..sel_3 in  1      select bits (sel_1 is the LSB)
//            out          out WIDTH  selected word
// Revision : 1.0 - initial release
// ============================================================================
module ejercicio_2_b #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  input  logic [WIDTH-1:0] in_5,
  input  logic [WIDTH-1:0] in_6,
  input  logic [WIDTH-1:0] in_7,
  input  logic [WIDTH-1:0] in_8,
  input  logic             sel_1,
  input  logic             sel_2,
  input  logic             sel_3,
  output logic [WIDTH-1:0] out
);

  logic [2:0] w_sel;
  assign w_sel = {sel_3, sel_2, sel_1};

  always_comb begin
    out = in_1;
    case (w_sel)
      3'd0:    out = in_1;
      3'd1:    out = in_2;
      3'd2:    out = in_3;
      3'd3:    out = in_4;
      3'd4:    out = in_5;
      3'd5:    out = in_6;
      3'd6:    out = in_7;
      3'd7:    out = in_8;
      default: out = in_1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ejercicio_3_rr_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ejercicio_3_rr_mux_ctrl
// Purpose  : Round-robin arbiter/sequencer sharing one 8:1 mux among eight
//            requesters; registers the granted word onto a valid/ready port.
// Ports    : clk, rst_n                 clock, async active-low reset
//            req_i[7:0], mask_i[7:0]    requests and per-requester enables
//            data_0_i..data_7_i         requester words (DATA_W bits)
//            out_valid_o/out_ready_i    output handshake
//            out_data_o                 registered output word
//            ack_o[7:0]                 one-hot ack in the handshake cycle
//            sel_o[2:0]                 current grant index
//            xfer_cnt_o[15:0]           completed transfers, modulo 2^16
// Revision : 1.0 - initial release
// ============================================================================
module ejercicio_3_rr_mux_ctrl
  import ejercicio_3_pkg::*;
#(
  parameter int DATA_W = 16   // must match the mux width; 16 only
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [DATA_W-1:0] data_0_i,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic [DATA_W-1:0] data_2_i,
  input  logic [DATA_W-1:0] data_3_i,
  input  logic [DATA_W-1:0] data_4_i,
  input  logic [DATA_W-1:0] data_5_i,
  input  logic [DATA_W-1:0] data_6_i,
  input  logic [DATA_W-1:0] data_7_i,
  input  logic [N_REQ-1:0]  mask_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [N_REQ-1:0]  ack_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [15:0]       xfer_cnt_o
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [15:0]        r_cnt;

  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_sel_onehot;
  logic [N_REQ-1:0]   w_arb_vec;
  logic [SEL_W:0]     w_pick;
  logic               w_found;
  logic [SEL_W-1:0]   w_win;
  logic               w_fire;
  logic               w_load;
  logic [SEL_W-1:0]   w_mux_sel;
  logic [DATA_W-1:0]  w_mux_out;

  assign w_elig       = req_i & mask_i;
  assign w_sel_onehot = N_REQ'(1) << r_sel;
  // out_valid_o is high exactly while in SEND, so state alone qualifies a fire
  assign w_fire       = (r_state == SEND) && out_ready_i;

  // The requester being acked this cycle is excluded from re-arbitration so
  // its (possibly unchanged) request cannot be granted twice in a row.
  assign w_arb_vec = (r_state == SEND) ? (w_elig & ~w_sel_onehot) : w_elig;
  assign w_pick    = rr_pick(w_arb_vec, r_ptr);
  assign w_found   = w_pick[SEL_W];
  assign w_win     = w_pick[SEL_W-1:0];
  assign w_load    = w_found && ((r_state == IDLE) || w_fire);

  // Point the mux at the incoming winner on a load edge so the captured word
  // belongs to the new grant; otherwise it follows the held grant.
  assign w_mux_sel = w_load ? w_win : r_sel;

  ejercicio_2_b #(
    .WIDTH (DATA_W)
  ) u_mux (
    .in_1  (data_0_i),
    .in_2  (data_1_i),
    .in_3  (data_2_i),
    .in_4  (data_3_i),
    .in_5  (data_4_i),
    .in_6  (data_5_i),
    .in_7  (data_6_i),
    .in_8  (data_7_i),
    .sel_1 (w_mux_sel[0]),
    .sel_2 (w_mux_sel[1]),
    .sel_3 (w_mux_sel[2]),
    .out   (w_mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= PTR_RESET;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_sel   <= w_win;
            r_ptr   <= w_win;
            r_data  <= w_mux_out;
            r_valid <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_fire) begin
            r_cnt <= r_cnt + 16'd1;
            if (w_load) begin
              r_sel  <= w_win;
              r_ptr  <= w_win;
              r_data <= w_mux_out;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign sel_o       = r_sel;
  assign xfer_cnt_o  = r_cnt;
  assign ack_o       = w_fire ? w_sel_onehot : '0;

endmodule
`default_nettype wire

// File: tb/tb_ejercicio_3_rr_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ejercicio_3_rr_mux_ctrl
// Purpose  : Self-checking bench for ejercicio_3_rr_mux_ctrl against a
//            transfer-level reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ejercicio_3_rr_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  mask;
  logic [15:0] td [8];
  logic        ready;

  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  ack;
  logic [2:0]  sel;
  logic [15:0] cnt;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic        m_valid;
  int          m_sel;
  int          m_ptr;
  logic [15:0] m_data;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  ejercicio_3_rr_mux_ctrl #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .data_0_i    (td[0]),
    .data_1_i    (td[1]),
    .data_2_i    (td[2]),
    .data_3_i    (td[3]),
    .data_4_i    (td[4]),
    .data_5_i    (td[5]),
    .data_6_i    (td[6]),
    .data_7_i    (td[7]),
    .mask_i      (mask),
    .out_valid_o (out_valid),
    .out_ready_i (ready),
    .out_data_o  (out_data),
    .ack_o       (ack),
    .sel_o       (sel),
    .xfer_cnt_o  (cnt)
  );

  function automatic int next_winner(input logic [7:0] v, input int last);
    for (int off = 1; off <= 8; off++)
      if (v[(last + off) % 8]) return (last + off) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] m_ack();
    return (m_valid && ready) ? (8'd1 << m_sel) : 8'h00;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_sel = 0; m_ptr = 7; m_data = 16'h0; m_cnt = 16'h0;
  endtask

  // One clock edge of the transfer rules, using the inputs present at the edge.
  task automatic model_edge();
    logic [7:0] e;
    int w;
    if (!rst_n) begin model_reset(); return; end
    e = req & mask;
    if (m_valid) begin
      if (!ready) return;
      m_cnt = m_cnt + 16'd1;
      e[m_sel] = 1'b0;
    end
    w = next_winner(e, m_ptr);
    if (w >= 0) begin
      m_sel = w; m_ptr = w; m_data = td[w]; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; mask = 8'hFF; ready = 1'b1;
    for (int k = 0; k < 8; k++) td[k] = 16'h1000 + 16'(k * 16'h0111);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || sel !== 3'd0 ||
        ack !== 8'h00 || cnt !== 16'h0) begin
      $display("FAIL reset_values: valid=%b data=%h sel=%0d ack=%h cnt=%h want 0/0000/0/00/0000",
               out_valid, out_data, sel, ack, cnt);
    end else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || sel !== 3'(i % 8) || out_data !== td[i % 8] ||
          ack !== (8'd1 << (i % 8)) || cnt !== 16'(i)) begin
        $display("FAIL reset_order[%0d]: valid=%b sel=%0d data=%h ack=%h cnt=%0d want 1/%0d/%h/%h/%0d",
                 i, out_valid, sel, out_data, ack, cnt, i % 8, td[i % 8], 8'd1 << (i % 8), i);
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 8'b0010_0100; mask = 8'hFF; ready = 1'b1;
    td[2] = 16'hAAAA; td[5] = 16'h5555;
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== ((j % 2) ? 16'hAAAA : 16'h5555) ||
          ack !== ((j % 2) ? 8'h04 : 8'h20) || cnt !== 16'(j - 1)) begin
        $display("FAIL back_to_back[%0d]: valid=%b data=%h ack=%h cnt=%0d want 1/%h/%h/%0d",
                 j, out_valid, out_data, ack, cnt,
                 (j % 2) ? 16'hAAAA : 16'h5555, (j % 2) ? 8'h04 : 8'h20, j - 1);
      end else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [15:0] word;
    apply_reset();
    word = 16'($urandom);
    req = 8'h08; mask = 8'hFF; ready = 1'b0; td[3] = word;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || sel !== 3'd3 || out_data !== word || ack !== 8'h00) begin
      $display("FAIL stall_grant: valid=%b sel=%0d data=%h ack=%h want 1/3/%h/00",
               out_valid, sel, out_data, ack, word);
    end else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || sel !== 3'd3 || out_data !== word || ack !== 8'h00) begin
        $display("FAIL stall_hold[%0d]: valid=%b sel=%0d data=%h ack=%h want 1/3/%h/00",
                 i, out_valid, sel, out_data, ack, word);
      end else n_pass++;
    end
    ready = 1'b1;
    #1;
    n_total++;
    if (ack !== 8'h08) $display("FAIL stall_ack: ack=%h want 08", ack);
    else n_pass++;
    tick();
    req = 8'h00;
    #1;
    n_total++;
    if (ack !== 8'h00 || out_valid !== 1'b0 || cnt !== 16'd1) begin
      $display("FAIL stall_after: ack=%h valid=%b cnt=%0d want 00/0/1", ack, out_valid, cnt);
    end else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    req = 8'h40; mask = 8'hFF; ready = 1'b1; td[6] = 16'hC0DE;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (out_valid !== ((i % 2) == 0) || ack !== (((i % 2) == 0) ? 8'h40 : 8'h00)) begin
        $display("FAIL single[%0d]: valid=%b ack=%h want %b/%h",
                 i, out_valid, ack, (i % 2) == 0, ((i % 2) == 0) ? 8'h40 : 8'h00);
      end else n_pass++;
    end
  endtask

  task automatic test_mask();
    apply_reset();
    req = 8'hFF; mask = 8'h81; ready = 1'b1;
    for (int k = 0; k < 8; k++) td[k] = 16'(16'hA000 + k);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || sel !== ((i % 2) ? 3'd7 : 3'd0) ||
          out_data !== td[(i % 2) ? 7 : 0]) begin
        $display("FAIL mask_alt[%0d]: valid=%b sel=%0d data=%h want 1/%0d",
                 i, out_valid, sel, out_data, (i % 2) ? 7 : 0);
      end else n_pass++;
    end
    // requester 7 is now held in SEND; disabling it must not cancel the word
    ready = 1'b0; mask = 8'h01;
    tick();
    ready = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b1 || sel !== 3'd7 || out_data !== td[7] || ack !== 8'h80) begin
      $display("FAIL mask_keep: valid=%b sel=%0d data=%h ack=%h want 1/7/%h/80",
               out_valid, sel, out_data, ack, td[7]);
    end else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || sel !== 3'd0) begin
      $display("FAIL mask_next: valid=%b sel=%0d want 1/0", out_valid, sel);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] acked;
    int errs;
    apply_reset();
    req = 8'h00; mask = 8'hFF; ready = 1'b1;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      acked = m_ack();
      tick();
      n_total++;
      if (out_valid !== m_valid || (m_valid && (sel !== 3'(m_sel) || out_data !== m_data)) ||
          cnt !== m_cnt) begin
        $display("FAIL random_regs[%0d]: valid=%b sel=%0d data=%h cnt=%h want %b/%0d/%h/%h",
                 c, out_valid, sel, out_data, cnt, m_valid, m_sel, m_data, m_cnt);
      end else n_pass++;
      // requesters only change their request/word at their own ack edge
      for (int k = 0; k < 8; k++) begin
        if (acked[k]) begin
          req[k] = ($urandom_range(0, 3) != 0);
          td[k]  = 16'($urandom);
        end else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          td[k]  = 16'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      #1;
      n_total++;
      if (ack !== m_ack()) begin
        $display("FAIL random_ack[%0d]: ack=%h want %h", c, ack, m_ack());
      end else n_pass++;
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    req = 8'b0010_0100; mask = 8'hFF; ready = 1'b1;
    td[2] = 16'h1234; td[5] = 16'h4321;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick();
    n_total++;
    if (cnt !== 16'hFFFF) $display("FAIL wrap_pre: cnt=%h want FFFF", cnt);
    else n_pass++;
    tick();
    n_total++;
    if (cnt !== 16'h0000 || out_valid !== 1'b1) begin
      $display("FAIL wrap_zero: cnt=%h valid=%b want 0000/1", cnt, out_valid);
    end else n_pass++;
    // reset asserted between edges while a word is pending
    ready = 1'b0;
    tick();
    rst_n = 1'b0;
    ready = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (out_valid !== 1'b0 || ack !== 8'h00 || cnt !== 16'h0000 || out_data !== 16'h0) begin
      $display("FAIL mid_reset: valid=%b ack=%h cnt=%h data=%h want 0/00/0000/0000",
               out_valid, ack, cnt, out_data);
    end else n_pass++;
    req = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || ack !== 8'h00 || cnt !== 16'h0000) begin
      $display("FAIL post_reset_idle: valid=%b ack=%h cnt=%h want 0/00/0000", out_valid, ack, cnt);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_single();
    test_mask();
    test_random();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ejercicio_3_rr_mux_ctrl.md
# ejercicio_3_rr_mux_ctrl

Round-robin arbiter and sequencer that shares the team's 16-bit 8:1 mux (`ejercicio_2_b`) among eight requesters. The block picks one pending requester, drives the mux's three select bits, registers the selected word, and presents it on a valid/ready output port. It also returns a per-requester acknowledge and keeps a running transfer count. It sits between eight producers and a single 16-bit consumer bus.

## Interface
- `DATA_W`, default 16: word width. It must equal the mux width, so 16 is the only legal value.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  8  per-requester request; bit k belongs to requester k.
- `data_0_i` .. `data_7_i`  in  16 each  requester words, feeding mux inputs `in_1`..`in_8`.
- `mask_i`  in  8  requester enable (1 = eligible), sampled only during arbitration.
- `out_valid_o`  out  1  `out_data_o` holds a word.
- `out_ready_i`  in  1  consumer accepts the word.
- `out_data_o`  out  16  registered output word.
- `ack_o`  out  8  one-hot; high for the granted requester in the handshake cycle.
- `sel_o`  out  3  current grant index, equal to {`sel_3`,`sel_2`,`sel_1`} of the mux.
- `xfer_cnt_o`  out  16  number of completed transfers.

## Operation
- **Eligible set:** E = `req_i` & `mask_i`.
- **Round-robin pointer:**
  - `ptr` holds the last granted index; its reset value is 7, so requester 0 wins first.
  - The winner is the first set bit of E, searching `ptr+1`, `ptr+2` … modulo 8.
- **State IDLE:**
  - If E≠0: set `sel` = winner, capture the mux output into `out_data_o`, set `out_valid_o`=1, update `ptr` = winner, go to SEND.
  - Otherwise stay in IDLE.
- **State SEND:**
  - The word is held stable while `out_ready_i`=0; there is no timeout.
  - On a fire (`out_valid_o` & `out_ready_i`):
    - `ack_o[sel]`=1, combinational, this cycle only.
    - `xfer_cnt_o` increments.
    - Re-arbitrate using E' = E with bit `sel` cleared.
    - If E'≠0: load the next winner exactly as in IDLE and stay in SEND, giving back-to-back transfers.
    - Otherwise clear `out_valid_o` and go to IDLE.
- **Requester protocol:**
  - Hold `req_i[k]` and `data_k_i` stable until `ack_o[k]`.
  - At the ack edge the requester may drop `req_i[k]`, or keep it high with a new word.
  - Dropping `req_i` before ack is a protocol violation. The captured word is still delivered and acked.
- **Masking:** `mask_i` changes take effect only at the next arbitration and never cancel the word already captured.
- **Counter:** `xfer_cnt_o` is 16-bit modulo, so 0xFFFF + 1 → 0x0000.
- **Reset mid-transfer:** the word is dropped. No ack is issued and nothing is counted.

## Timing
- **Reset values:** `out_valid_o`=0, `out_data_o`=0, `sel_o`=0, `ack_o`=0, `xfer_cnt_o`=0, `ptr`=7, state IDLE.
- **Latency:** request seen in IDLE at edge t → `out_valid_o`=1 after edge t, carrying the data sampled at edge t. That is one cycle from request to valid.
- **Throughput:** 1 word/cycle when at least two requesters alternate. A single requester gets 1 word per 2 cycles, because of the IDLE bubble.
- **Ack:** `ack_o` is a combinational function of state, `sel` and `out_ready_i`. It is never asserted while `out_valid_o`=0.
- **`sel_o`:** changes only at a load edge and is stable throughout SEND.

## Structure
- **Shared package `ejercicio_3_pkg`:**
  - state enum {IDLE, SEND}.
  - `N_REQ`=8, `SEL_W`=3, `PTR_RESET`=3'd7.
  - round-robin function `rr_pick(vec, ptr)`, which returns {found, idx}.
- **Sub-module:** instantiate the existing `ejercicio_2_b` for the datapath. `sel_1`=`sel[0]`, `sel_2`=`sel[1]`, `sel_3`=`sel[2]`.
- **Select timing:** the mux select is driven from the next-grant index at load time, so the captured word matches the new grant.

## Test plan
- **Reset:**
  - Stimulus: `rst_n`=0 with all `req_i`=1.
  - Response: every output at its reset value, `ack_o`=0.
  - After release with `req_i`=8'hFF and `out_ready_i`=1, the grant order is 0,1,…,7,0, with `out_data_o` matching each `data_k_i`.
- **Back-to-back:**
  - Stimulus: `req_i`=8'b0010_0100, `data_2_i`=16'hAAAA, `data_5_i`=16'h5555, `out_ready_i`=1.
  - Response: alternating AAAA/5555 every cycle, `ack_o` alternating 0x04/0x20, and `xfer_cnt_o` +1 per cycle.
- **Stall:**
  - Stimulus: grant to requester 3, then `out_ready_i`=0 for 5 cycles.
  - Response: `out_data_o`, `sel_o`=3 and `out_valid_o` held; `ack_o`=0.
  - When `out_ready_i` rises: `ack_o`=0x08 for exactly 1 cycle.
- **Single requester:**
  - Stimulus: only `req_i[6]` held high.
  - Response: valid pattern 1,0,1,0,… with `ack_o[6]` on each fire.
- **Mask:**
  - Stimulus: `req_i`=8'hFF, `mask_i`=8'h81.
  - Response: grants alternate 0,7 only.
  - Clearing `mask_i[7]` while 7 is in SEND still delivers that word.
- **Wrap and reset:**
  - Force `xfer_cnt_o` to 0xFFFF, then complete one fire → 0x0000.
  - Assert `rst_n` low during SEND → `out_valid_o` drops immediately, with no ack.
